raven_gpio_bank: RTL and testbench
==================================

# raven_gpio_bank

Parametrised GPIO bank between the SoC core's gpio_out/gpio_outenb/gpio_in vectors and the PADINOUT pad cells. It replaces direct per-pin wiring with:
- a registered output path;
- a metastability-safe input path with configurable synchroniser depth;
- per-pin edge-detect interrupts with a sticky pending register and masking;
- an optional debounce filter.

The bank width is configurable through NUM_GPIO.

## Interface
Parameters:
- NUM_GPIO, 16, number of pins in the bank (1..32).
- SYNC_STAGES, 2, input synchroniser flops per pin (2..4).
- DEBOUNCE_CNT, 8, consecutive stable cycles needed to accept a new input level (2..255). Used only with RAVEN_GPIO_DEBOUNCE_EN.

Ports:
- pll_clk  in  1  sole clock; every flop is clocked on its rising edge.
- resetb  in  1  asynchronous, active-low reset.
- gpio_out  in  NUM_GPIO  core output data.
- gpio_outenb  in  NUM_GPIO  core output enable, active-low (1 = pin is an input).
- gpio_in  out  NUM_GPIO  synchronised (and filtered, when enabled) pin level to the core.
- pad_do  out  NUM_GPIO  to PADINOUT DO.
- pad_oeb  out  NUM_GPIO  to PADINOUT OEN.
- pad_di  in  NUM_GPIO  from PADINOUT DI; asynchronous to pll_clk.
- irq_mode  in  2*NUM_GPIO  per-pin edge mode; pin i uses bits [2i+1:2i]. 00 = off, 01 = rising, 10 = falling, 11 = both.
- irq_mask  in  NUM_GPIO  1 = pin may drive irq.
- irq_clear  in  NUM_GPIO  single-cycle pulse; clears the corresponding pending bit.
- irq_pending  out  NUM_GPIO  sticky pending flags.
- irq  out  1  OR-reduction of irq_pending & irq_mask.

## Operation
Output path:
- pad_do and pad_oeb are registered copies of gpio_out and gpio_outenb.

Input path:
- pad_di passes through a chain of SYNC_STAGES flops to give sync[i].
- Without debounce, gpio_in = sync.

Debounce (when compiled in):
- Each pin has a filtered register filt[i] and a counter cnt[i] of width clog2(DEBOUNCE_CNT+1).
- When sync[i] equals filt[i], cnt[i] is held at 0.
- Otherwise cnt[i] increments by 1 each cycle.
- When cnt[i] reaches DEBOUNCE_CNT-1 while sync[i] still differs, filt[i] takes sync[i] on the next edge and cnt[i] returns to 0.
- Any cycle in which sync[i] equals filt[i] before that point resets cnt[i] to 0, so glitches are rejected.
- gpio_in = filt.

Edge detection:
- A register prev holds the gpio_in value from the previous cycle.
- rise[i] = gpio_in[i] & ~prev[i]; fall[i] = ~gpio_in[i] & prev[i].
- edge[i] is qualified by irq_mode[i]: 00 never, 01 rise, 10 fall, 11 rise|fall.
- Output pins (pad_oeb = 0) are still monitored, because the pad's DI reflects the driven level.

Warm-up:
- A counter of SYNC_STAGES+1 cycles starts when resetb deasserts.
- While it runs, edge is forced to 0 and prev simply tracks gpio_in.
- This prevents a spurious edge caused by the reset-0 synchroniser contents.

Pending register:
- irq_pending[i] sets on edge[i] and holds until irq_clear[i].
- If edge[i] and irq_clear[i] occur in the same cycle, set wins.
- Changing irq_mode or irq_mask never alters irq_pending.
- irq = |(irq_pending & irq_mask), combinational from registers, so it changes in the same cycle as irq_pending or irq_mask.

## Timing
Reset values while resetb = 0:
- pad_do, gpio_in, irq_pending and irq are 0.
- pad_oeb is all 1s (every pin an input).
- The synchroniser, filt, cnt, prev and warm-up counter are 0.

Latencies:
- gpio_out/gpio_outenb to pad_do/pad_oeb: 1 cycle.
- pad_di to gpio_in without debounce: SYNC_STAGES cycles.
- pad_di to gpio_in with debounce: SYNC_STAGES + DEBOUNCE_CNT cycles.
- Change on gpio_in to irq_pending and irq: 1 cycle.
- irq_clear to irq_pending = 0: 1 cycle.

Reset mid-operation:
- Asserting resetb clears every register immediately and asynchronously.
- Warm-up restarts when resetb deasserts.

## Configuration
- RAVEN_GPIO_DEBOUNCE_EN defined: the filt/cnt filter is instantiated per pin and DEBOUNCE_CNT is honoured.
- RAVEN_GPIO_DEBOUNCE_EN undefined: no filter logic exists, gpio_in = sync, and DEBOUNCE_CNT is ignored.

## Structure
- Package raven_gpio_pkg holds:
  - the irq_mode enum: IRQ_OFF = 2'b00, IRQ_RISE = 2'b01, IRQ_FALL = 2'b10, IRQ_BOTH = 2'b11;
  - the range limits for NUM_GPIO, SYNC_STAGES and DEBOUNCE_CNT.
- One sub-module, raven_gpio_pin, contains the per-pin logic: synchroniser, optional debounce, prev, edge detection and the pending bit. It is instantiated NUM_GPIO times with a generate loop.
- The top level owns the shared warm-up counter, the output registers and the irq OR-reduction.

## Test plan
- Reset and warm-up: hold pad_di = all 1s through reset, then release. Required: pad_oeb = 16'hFFFF and irq_pending = 0 throughout; gpio_in = 16'hFFFF after 2 cycles; no pending bit ever sets.
- Rising-edge interrupt: irq_mode[1:0] = 01, irq_mask[0] = 1; pad_di[0] goes 0 to 1. Required: gpio_in[0] rises 2 cycles later and irq_pending[0] = irq = 1 one cycle after that. A falling edge on the same pin causes no new event.
- Both-edge mode with mask: irq_mode[7:6] = 11, irq_mask[3] = 0; toggle pin 3 twice. Required: irq_pending[3] = 1 and irq = 0; setting irq_mask[3] = 1 gives irq = 1 in the same cycle.
- Clear vs set: pulse irq_clear[0] in the same cycle edge[0] occurs. Required: irq_pending[0] stays 1. A clear with no edge gives irq_pending[0] = 0 next cycle.
- Output path: gpio_outenb = 16'hFF00, gpio_out = 16'h00A5. Required: pad_oeb = 16'hFF00 and pad_do = 16'h00A5 one cycle later.
- Debounce (RAVEN_GPIO_DEBOUNCE_EN, DEBOUNCE_CNT = 8): a 5-cycle high glitch on pad_di[2] leaves gpio_in[2] = 0. A sustained high gives gpio_in[2] = 1 exactly 10 cycles after pad_di rises.

Source files
------------

// File: rtl/raven_gpio_pkg.sv
// raven_gpio_pkg: irq edge-mode encoding, parameter range limits and the edge qualifier.
// No timing or backpressure of its own; shared by the GPIO bank, its interface and its pins.
package raven_gpio_pkg;

  typedef enum logic [1:0] {
    IRQ_OFF  = 2'b00,
    IRQ_RISE = 2'b01,
    IRQ_FALL = 2'b10,
    IRQ_BOTH = 2'b11
  } irq_mode_e;

  localparam int NUM_GPIO_MIN     = 1;
  localparam int NUM_GPIO_MAX     = 32;
  localparam int SYNC_STAGES_MIN  = 2;
  localparam int SYNC_STAGES_MAX  = 4;
  localparam int DEBOUNCE_CNT_MIN = 2;
  localparam int DEBOUNCE_CNT_MAX = 255;

  // Wide enough to count SYNC_STAGES_MAX + 1 warm-up cycles.
  localparam int WARM_CNT_W = $clog2(SYNC_STAGES_MAX + 2);

  function automatic logic edge_hit(irq_mode_e mode, logic rise, logic fall);
    logic hit;
    hit = 1'b0;
    case (mode)
      IRQ_RISE: hit = rise;
      IRQ_FALL: hit = fall;
      IRQ_BOTH: hit = rise | fall;
      default:  hit = 1'b0;
    endcase
    return hit;
  endfunction

endpackage

// File: rtl/raven_gpio_bank_if.sv
// raven_gpio_bank_if: core-side and pad-side vectors of the GPIO bank; master = core + pads, slave = bank.
// Pure wiring: no latency, no backpressure.
interface raven_gpio_bank_if #(
  parameter int NUM_GPIO = 16
);
  import raven_gpio_pkg::*;

  logic [NUM_GPIO-1:0]   gpio_out;
  logic [NUM_GPIO-1:0]   gpio_outenb;
  logic [NUM_GPIO-1:0]   gpio_in;
  logic [NUM_GPIO-1:0]   pad_do;
  logic [NUM_GPIO-1:0]   pad_oeb;
  logic [NUM_GPIO-1:0]   pad_di;
  logic [2*NUM_GPIO-1:0] irq_mode;
  logic [NUM_GPIO-1:0]   irq_mask;
  logic [NUM_GPIO-1:0]   irq_clear;
  logic [NUM_GPIO-1:0]   irq_pending;
  logic                  irq;

  // pad_di is driven by the pad cells, so it sits with the core on the master side.
  modport master (
    output gpio_out, gpio_outenb, pad_di, irq_mode, irq_mask, irq_clear,
    input  gpio_in, pad_do, pad_oeb, irq_pending, irq
  );

  modport slave (
    input  gpio_out, gpio_outenb, pad_di, irq_mode, irq_mask, irq_clear,
    output gpio_in, pad_do, pad_oeb, irq_pending, irq
  );

endinterface

// File: rtl/raven_gpio_pin.sv
// raven_gpio_pin: synchroniser, optional debounce (RAVEN_GPIO_DEBOUNCE_EN), prev, edge detect, sticky pending.
// Latency: SYNC_STAGES (+DEBOUNCE_CNT) pad_di->gpio_in, +1 to irq_pending; no backpressure.
module raven_gpio_pin
  import raven_gpio_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CNT = 8
) (
  input  logic      clk,
  input  logic      rst_n,
  input  logic      pad_di,
  input  irq_mode_e irq_mode,
  input  logic      irq_clear,
  input  logic      warm_active,
  output logic      gpio_in,
  output logic      irq_pending
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   sync;
  logic                   prev_q, prev_d;
  logic                   pend_q, pend_d;
  logic                   rise, fall, evt;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], pad_di};
  end

  assign sync = sync_q[SYNC_STAGES-1];

`ifdef RAVEN_GPIO_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DEBOUNCE_CNT + 1);

  logic             filt_q, filt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // A new level is accepted only after DEBOUNCE_CNT consecutive differing samples.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (sync != filt_q) begin
      if (cnt_q == CNT_W'(DEBOUNCE_CNT - 1)) begin
        filt_d = sync;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q <= 1'b0;
      cnt_q  <= '0;
    end else begin
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end

  assign gpio_in = filt_q;
`else
  assign gpio_in = sync;
`endif

  assign rise = gpio_in & ~prev_q;
  assign fall = ~gpio_in & prev_q;

  always_comb begin
    evt    = ~warm_active & edge_hit(irq_mode, rise, fall);
    prev_d = gpio_in;
    pend_d = evt | (pend_q & ~irq_clear);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      pend_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      pend_q <= pend_d;
    end
  end

  assign irq_pending = pend_q;

endmodule

// File: rtl/raven_gpio_bank.sv
// raven_gpio_bank: registered pad outputs, per-pin input/irq logic, warm-up gate, irq OR; RAVEN_GPIO_DEBOUNCE_EN adds filtering.
// Latency: 1 cycle to pad_do/pad_oeb, SYNC_STAGES(+DEBOUNCE_CNT) to gpio_in; no backpressure.
module raven_gpio_bank
  import raven_gpio_pkg::*;
#(
  parameter int NUM_GPIO     = 16,
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CNT = 8
) (
  input  logic                    pll_clk,
  input  logic                    resetb,
  raven_gpio_bank_if.slave        bus
);

  localparam logic [WARM_CNT_W-1:0] WARM_CYCLES = WARM_CNT_W'(SYNC_STAGES + 1);

  logic [WARM_CNT_W-1:0] warm_cnt_q, warm_cnt_d;
  logic                  warm_active;
  logic [NUM_GPIO-1:0]   pad_do_q, pad_do_d;
  logic [NUM_GPIO-1:0]   pad_oeb_q, pad_oeb_d;
  logic [NUM_GPIO-1:0]   gpio_in_w;
  logic [NUM_GPIO-1:0]   pend_w;

  // Edges are suppressed until the reset-zero synchroniser contents have flushed.
  assign warm_active = (warm_cnt_q != WARM_CYCLES);

  always_comb begin
    warm_cnt_d = warm_cnt_q;
    if (warm_active) begin
      warm_cnt_d = warm_cnt_q + WARM_CNT_W'(1);
    end
    pad_do_d  = bus.gpio_out;
    pad_oeb_d = bus.gpio_outenb;
  end

  always_ff @(posedge pll_clk or negedge resetb) begin
    if (!resetb) begin
      warm_cnt_q <= '0;
      pad_do_q   <= '0;
      pad_oeb_q  <= '1;
    end else begin
      warm_cnt_q <= warm_cnt_d;
      pad_do_q   <= pad_do_d;
      pad_oeb_q  <= pad_oeb_d;
    end
  end

  for (genvar i = 0; i < NUM_GPIO; i++) begin : g_pin
    raven_gpio_pin #(
      .SYNC_STAGES  (SYNC_STAGES),
      .DEBOUNCE_CNT (DEBOUNCE_CNT)
    ) u_pin (
      .clk         (pll_clk),
      .rst_n       (resetb),
      .pad_di      (bus.pad_di[i]),
      .irq_mode    (irq_mode_e'(bus.irq_mode[2*i +: 2])),
      .irq_clear   (bus.irq_clear[i]),
      .warm_active (warm_active),
      .gpio_in     (gpio_in_w[i]),
      .irq_pending (pend_w[i])
    );
  end

  assign bus.pad_do      = pad_do_q;
  assign bus.pad_oeb     = pad_oeb_q;
  assign bus.gpio_in     = gpio_in_w;
  assign bus.irq_pending = pend_w;
  assign bus.irq         = |(pend_w & bus.irq_mask);

endmodule

// File: tb/tb_raven_gpio_bank.sv
// tb_raven_gpio_bank: directed scenarios plus randomized traffic against a cycle-level reference model.
// Compile with RAVEN_GPIO_DEBOUNCE_EN defined to exercise the debounce filter.
module tb_raven_gpio_bank;

  localparam int N  = 16;
  localparam int S  = 2;
  localparam int DB = 8;
`ifdef RAVEN_GPIO_DEBOUNCE_EN
  localparam int LAT = S + DB;
`else
  localparam int LAT = S;
`endif
  localparam int WARM = S + 1;

  logic pll_clk = 1'b0;
  logic resetb  = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  raven_gpio_bank_if #(.NUM_GPIO(N)) bus ();

  raven_gpio_bank #(
    .NUM_GPIO     (N),
    .SYNC_STAGES  (S),
    .DEBOUNCE_CNT (DB)
  ) dut (
    .pll_clk (pll_clk),
    .resetb  (resetb),
    .bus     (bus)
  );

  always #5 pll_clk = ~pll_clk;

  // Reference model: gpio_in is the pad level seen S edges earlier (then filtered),
  // pending latches qualified changes of gpio_in once warm-up has elapsed.
  logic [N-1:0] hist[$];
  logic [N-1:0] m_gin, m_gin_old, m_pend, m_do, m_oeb, m_sync_prev, m_filt;
  int           m_n;
  int           run[N];

  function automatic void model_reset();
    hist.delete();
    m_gin = '0; m_gin_old = '0; m_pend = '0; m_do = '0; m_oeb = '1;
    m_sync_prev = '0; m_filt = '0; m_n = 0;
    for (int i = 0; i < N; i++) run[i] = 0;
  endfunction

  function automatic void model_edge();
    logic [N-1:0] ev, sync_now;
    logic [1:0]   md;
    logic         r, f;
    m_n++;
    ev = '0;
    for (int i = 0; i < N; i++) begin
      r  = m_gin[i] && !m_gin_old[i];
      f  = !m_gin[i] && m_gin_old[i];
      md = bus.irq_mode[2*i +: 2];
      case (md)
        2'b01:   ev[i] = r;
        2'b10:   ev[i] = f;
        2'b11:   ev[i] = r || f;
        default: ev[i] = 1'b0;
      endcase
    end
    if (m_n <= WARM) ev = '0;
    m_pend    = (m_pend & ~bus.irq_clear) | ev;
    m_gin_old = m_gin;
    hist.push_back(bus.pad_di);
    if (hist.size() > 8) void'(hist.pop_front());
    sync_now = (hist.size() >= S) ? hist[hist.size() - S] : '0;
`ifdef RAVEN_GPIO_DEBOUNCE_EN
    for (int i = 0; i < N; i++) begin
      if (m_sync_prev[i] != m_filt[i]) begin
        run[i]++;
        if (run[i] == DB) begin
          m_filt[i] = m_sync_prev[i];
          run[i] = 0;
        end
      end else begin
        run[i] = 0;
      end
    end
    m_sync_prev = sync_now;
    m_gin = m_filt;
`else
    m_gin = sync_now;
`endif
    m_do  = bus.gpio_out;
    m_oeb = bus.gpio_outenb;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("gpio_in",     32'(bus.gpio_in),     32'(m_gin));
    chk("pad_do",      32'(bus.pad_do),      32'(m_do));
    chk("pad_oeb",     32'(bus.pad_oeb),     32'(m_oeb));
    chk("irq_pending", 32'(bus.irq_pending), 32'(m_pend));
    chk("irq",         32'(bus.irq),         32'(|(m_pend & bus.irq_mask)));
  endtask

  task automatic step();
    @(posedge pll_clk);
    if (resetb) model_edge();
    @(negedge pll_clk);
    check_all();
    bus.irq_clear = '0;
  endtask

  initial begin
    bus.gpio_out    = '0;
    bus.gpio_outenb = '1;
    bus.pad_di      = '1;
    bus.irq_mode    = '0;
    bus.irq_mask    = '0;
    bus.irq_clear   = '0;
    model_reset();
    #2 resetb = 1'b0;

    // Reset and warm-up with every pad high.
    repeat (3) step();
    chk("rst_oeb", 32'(bus.pad_oeb), 32'h0000_FFFF);
    resetb = 1'b1;
    repeat (LAT) step();
    chk("warm_gin", 32'(bus.gpio_in), 32'h0000_FFFF);
    repeat (4) step();
    chk("warm_pend", 32'(bus.irq_pending), 32'h0);

    // Rising-edge interrupt on pin 0.
    bus.pad_di = 16'hFFFE;
    repeat (LAT + 2) step();
    bus.irq_mode[1:0] = 2'b01;
    bus.irq_mask[0]   = 1'b1;
    bus.pad_di[0]     = 1'b1;
    repeat (LAT) step();
    chk("rise_gin", 32'(bus.gpio_in[0]), 32'h1);
    chk("rise_pend_early", 32'(bus.irq_pending[0]), 32'h0);
    step();
    chk("rise_pend", 32'(bus.irq_pending[0]), 32'h1);
    chk("rise_irq", 32'(bus.irq), 32'h1);
    bus.irq_clear[0] = 1'b1;
    step();
    chk("clr_pend", 32'(bus.irq_pending[0]), 32'h0);
    bus.pad_di[0] = 1'b0;
    repeat (LAT + 2) step();
    chk("fall_ignored", 32'(bus.irq_pending[0]), 32'h0);
    chk("fall_irq", 32'(bus.irq), 32'h0);

    // Both-edge mode on masked pin 3.
    bus.irq_mode[7:6] = 2'b11;
    bus.pad_di[3] = 1'b0;
    repeat (LAT + 1) step();
    bus.pad_di[3] = 1'b1;
    repeat (LAT + 1) step();
    chk("both_pend", 32'(bus.irq_pending[3]), 32'h1);
    chk("both_irq_masked", 32'(bus.irq), 32'h0);
    bus.irq_mask[3] = 1'b1;
    #1 chk("both_irq_unmask", 32'(bus.irq), 32'h1);

    // Set beats a coincident clear; a lone clear then empties the bit.
    bus.pad_di[0] = 1'b1;
    repeat (LAT) step();
    bus.irq_clear[0] = 1'b1;
    step();
    chk("set_wins", 32'(bus.irq_pending[0]), 32'h1);
    bus.irq_clear[0] = 1'b1;
    step();
    chk("clear_alone", 32'(bus.irq_pending[0]), 32'h0);

    // Output path.
    bus.gpio_outenb = 16'hFF00;
    bus.gpio_out    = 16'h00A5;
    step();
    chk("out_oeb", 32'(bus.pad_oeb), 32'h0000_FF00);
    chk("out_do",  32'(bus.pad_do),  32'h0000_00A5);

`ifdef RAVEN_GPIO_DEBOUNCE_EN
    // Short glitch rejected; sustained level accepted after S + DB cycles.
    bus.pad_di[2] = 1'b0;
    repeat (LAT + 2) step();
    bus.pad_di[2] = 1'b1;
    repeat (5) step();
    bus.pad_di[2] = 1'b0;
    repeat (12) step();
    chk("glitch_rejected", 32'(bus.gpio_in[2]), 32'h0);
    bus.pad_di[2] = 1'b1;
    repeat (9) step();
    chk("db_not_yet", 32'(bus.gpio_in[2]), 32'h0);
    step();
    chk("db_accept", 32'(bus.gpio_in[2]), 32'h1);
`endif

    // Randomized traffic with an asynchronous reset in the middle.
    for (int c = 0; c < 400; c++) begin
      if (c == 200) begin
        #2 resetb = 1'b0;
        #1;
        chk("arst_gin",  32'(bus.gpio_in),     32'h0);
        chk("arst_do",   32'(bus.pad_do),      32'h0);
        chk("arst_oeb",  32'(bus.pad_oeb),     32'h0000_FFFF);
        chk("arst_pend", 32'(bus.irq_pending), 32'h0);
        chk("arst_irq",  32'(bus.irq),         32'h0);
        model_reset();
        repeat (2) step();
        resetb = 1'b1;
      end
      if ($urandom_range(0, 2) == 0) bus.pad_di = bus.pad_di ^ (16'($urandom) & 16'($urandom));
      if ((c % 25) == 0) bus.irq_mode = $urandom;
      if ((c % 10) == 0) bus.irq_mask = 16'($urandom);
      bus.irq_clear   = 16'($urandom) & 16'($urandom) & 16'($urandom);
      bus.gpio_out    = 16'($urandom);
      bus.gpio_outenb = 16'($urandom);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
